// File: rtl/sys_bus_master_if.sv
// ---------------------------------------------------------------------------
// sys_bus_master_if
// Groups the command port, the response port and the system-bus request/reply
// signals of sys_bus_master. Signal names keep the initiator's point of view
// (_i = driven towards the initiator, _o = driven by the initiator).
//
// Modports:
//   master : used by sys_bus_master (drives cmd_ready/rsp_*/busy/sys_* requests)
//   slave  : mirror view for whatever sits around the initiator
//            (command source, response sink and bus slave)
// ---------------------------------------------------------------------------
interface sys_bus_master_if;
   // Command port
   logic        cmd_valid_i;
   logic        cmd_ready_o;
   logic        cmd_we_i;
   logic [31:0] cmd_addr_i;
   logic [31:0] cmd_wdata_i;
   logic [3:0]  cmd_sel_i;
   // Response port
   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [31:0] rsp_rdata_o;
   logic        rsp_err_o;
   logic        rsp_timeout_o;
   logic        busy_o;
   // System bus
   logic [31:0] sys_addr_o;
   logic [31:0] sys_wdata_o;
   logic [3:0]  sys_sel_o;
   logic        sys_wen_o;
   logic        sys_ren_o;
   logic [31:0] sys_rdata_i;
   logic        sys_err_i;
   logic        sys_ack_i;

   modport master (
      input  cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_wdata_i, cmd_sel_i,
      input  rsp_ready_i,
      input  sys_rdata_i, sys_err_i, sys_ack_i,
      output cmd_ready_o,
      output rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o, busy_o,
      output sys_addr_o, sys_wdata_o, sys_sel_o, sys_wen_o, sys_ren_o
   );

   modport slave (
      output cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_wdata_i, cmd_sel_i,
      output rsp_ready_i,
      output sys_rdata_i, sys_err_i, sys_ack_i,
      input  cmd_ready_o,
      input  rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o, busy_o,
      input  sys_addr_o, sys_wdata_o, sys_sel_o, sys_wen_o, sys_ren_o
   );
endinterface

// File: rtl/sys_bus_master.sv
// ---------------------------------------------------------------------------
// sys_bus_master
// System-bus initiator: takes one read/write command at a time on a
// valid/ready port, issues a single-cycle sys_wen/sys_ren strobe with
// registered address/data/selects, waits for sys_ack, and presents read data
// plus error status on a valid/ready response port.
//
// Optional feature (compile-time macro SYS_BUS_MASTER_TIMEOUT_EN):
//   when defined, a transfer that sees no ack for TIMEOUT_CYC WAIT cycles is
//   aborted with rdata=0xFFFFFFFF, err=1, timeout=1. When undefined, no
//   counter exists, rsp_timeout_o is tied low and WAIT lasts until ack/reset.
//
// Parameters:
//   TIMEOUT_CYC  WAIT-cycle limit before abort (2..65535), timeout build only
// Ports:
//   sys_clk_i    clock shared with the bus slaves
//   sys_rst_i    asynchronous active-high reset
//   bus          sys_bus_master_if.master (command, response, system bus)
// ---------------------------------------------------------------------------
module sys_bus_master #(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic               sys_clk_i,
   input  logic               sys_rst_i,
   sys_bus_master_if.master   bus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
      $error("sys_bus_master: TIMEOUT_CYC must be within 2..65535");
   end

   logic [1:0]  state_q,       state_d;
   logic [31:0] sys_addr_q,    sys_addr_d;
   logic [31:0] sys_wdata_q,   sys_wdata_d;
   logic [3:0]  sys_sel_q,     sys_sel_d;
   logic        sys_wen_q,     sys_wen_d;
   logic        sys_ren_q,     sys_ren_d;
   logic        we_q,          we_d;
   logic        rsp_valid_q,   rsp_valid_d;
   logic [31:0] rsp_rdata_q,   rsp_rdata_d;
   logic        rsp_err_q,     rsp_err_d;

`ifdef SYS_BUS_MASTER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rsp_timeout_q, rsp_timeout_d;
`endif

   always_comb begin
      state_d     = state_q;
      sys_addr_d  = sys_addr_q;
      sys_wdata_d = sys_wdata_q;
      sys_sel_d   = sys_sel_q;
      we_d        = we_q;
      // Strobes are single-cycle: they default low every cycle.
      sys_wen_d   = 1'b0;
      sys_ren_d   = 1'b0;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
`ifdef SYS_BUS_MASTER_TIMEOUT_EN
      cnt_d         = cnt_q;
      rsp_timeout_d = rsp_timeout_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (bus.cmd_valid_i) begin
               sys_addr_d  = bus.cmd_addr_i;
               sys_wdata_d = bus.cmd_wdata_i;
               sys_sel_d   = bus.cmd_sel_i;
               we_d        = bus.cmd_we_i;
               sys_wen_d   = bus.cmd_we_i;
               sys_ren_d   = ~bus.cmd_we_i;
               state_d     = ST_WAIT;
`ifdef SYS_BUS_MASTER_TIMEOUT_EN
               cnt_d       = '0;
`endif
            end
         end
         ST_WAIT: begin
`ifdef SYS_BUS_MASTER_TIMEOUT_EN
            // Saturating count of WAIT cycles.
            if (cnt_q != CNT_W'(TIMEOUT_CYC))
               cnt_d = cnt_q + CNT_W'(1);
`endif
            // Ack is checked first so it wins over a coincident timeout.
            if (bus.sys_ack_i) begin
               rsp_rdata_d = we_q ? 32'h0 : bus.sys_rdata_i;
               rsp_err_d   = bus.sys_err_i;
               rsp_valid_d = 1'b1;
               state_d     = ST_RESP;
`ifdef SYS_BUS_MASTER_TIMEOUT_EN
               rsp_timeout_d = 1'b0;
            end else if (cnt_q >= CNT_W'(TIMEOUT_CYC - 1)) begin
               // This WAIT cycle is number TIMEOUT_CYC since the accept.
               rsp_rdata_d   = 32'hFFFF_FFFF;
               rsp_err_d     = 1'b1;
               rsp_timeout_d = 1'b1;
               rsp_valid_d   = 1'b1;
               state_d       = ST_RESP;
`endif
            end
         end
         ST_RESP: begin
            if (bus.rsp_ready_i) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         state_q     <= ST_IDLE;
         sys_addr_q  <= '0;
         sys_wdata_q <= '0;
         sys_sel_q   <= '0;
         sys_wen_q   <= 1'b0;
         sys_ren_q   <= 1'b0;
         we_q        <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
`ifdef SYS_BUS_MASTER_TIMEOUT_EN
         cnt_q         <= '0;
         rsp_timeout_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         sys_addr_q  <= sys_addr_d;
         sys_wdata_q <= sys_wdata_d;
         sys_sel_q   <= sys_sel_d;
         sys_wen_q   <= sys_wen_d;
         sys_ren_q   <= sys_ren_d;
         we_q        <= we_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
`ifdef SYS_BUS_MASTER_TIMEOUT_EN
         cnt_q         <= cnt_d;
         rsp_timeout_q <= rsp_timeout_d;
`endif
      end
   end

   // Ready depends on state only, never on cmd_valid_i.
   assign bus.cmd_ready_o = (state_q == ST_IDLE);
   assign bus.busy_o      = (state_q != ST_IDLE);
   assign bus.sys_addr_o  = sys_addr_q;
   assign bus.sys_wdata_o = sys_wdata_q;
   assign bus.sys_sel_o   = sys_sel_q;
   assign bus.sys_wen_o   = sys_wen_q;
   assign bus.sys_ren_o   = sys_ren_q;
   assign bus.rsp_valid_o = rsp_valid_q;
   assign bus.rsp_rdata_o = rsp_rdata_q;
   assign bus.rsp_err_o   = rsp_err_q;
`ifdef SYS_BUS_MASTER_TIMEOUT_EN
   assign bus.rsp_timeout_o = rsp_timeout_q;
`else
   assign bus.rsp_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_sys_bus_master.sv
// ---------------------------------------------------------------------------
// tb_sys_bus_master
// Directed bench for sys_bus_master: writes, reads, backpressure, slave
// error, zero-latency slave, stray acks, timeout (or its absence) and reset
// in the middle of a transfer. The slave model can ack one cycle after the
// strobe (registered), in the strobe cycle (combinational) or under manual
// control from the tasks.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sys_bus_master;

   localparam int unsigned TC = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sys_bus_master_if bus_if();

   sys_bus_master #(.TIMEOUT_CYC(TC)) dut (
      .sys_clk_i (clk),
      .sys_rst_i (rst),
      .bus       (bus_if)
   );

   // Slave model: 0 = registered ack, 1 = combinational ack, 2 = manual
   logic [1:0]  slave_mode  = 2'd0;
   logic        man_ack     = 1'b0;
   logic [31:0] slave_rdata = 32'h0;
   logic        slave_err   = 1'b0;
   logic        reg_ack;

   always @(posedge clk or posedge rst) begin
      if (rst) reg_ack <= 1'b0;
      else     reg_ack <= bus_if.sys_wen_o | bus_if.sys_ren_o;
   end

   assign bus_if.sys_ack_i   = (slave_mode == 2'd0) ? reg_ack :
                               (slave_mode == 2'd1) ? (bus_if.sys_wen_o | bus_if.sys_ren_o) :
                               man_ack;
   assign bus_if.sys_rdata_i = slave_rdata;
   assign bus_if.sys_err_i   = slave_err;

   // Strobe counters, sampled at the edge (pre-update values).
   int wen_cnt = 0;
   int ren_cnt = 0;
   always @(posedge clk) begin
      if (bus_if.sys_wen_o === 1'b1) wen_cnt++;
      if (bus_if.sys_ren_o === 1'b1) ren_cnt++;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a command so that the next edge accepts it, then withdraw it.
   task automatic issue(input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] sel);
      bus_if.cmd_valid_i = 1'b1;
      bus_if.cmd_we_i    = we;
      bus_if.cmd_addr_i  = addr;
      bus_if.cmd_wdata_i = wdata;
      bus_if.cmd_sel_i   = sel;
      tick();
      bus_if.cmd_valid_i = 1'b0;
   endtask

   // Count cycles from the accept edge until rsp_valid_o, bounded by max_cyc.
   task automatic wait_rsp(input int max_cyc, output int lat);
      lat = 0;
      while (bus_if.rsp_valid_o !== 1'b1 && lat < max_cyc) begin
         tick();
         lat++;
      end
      $display("txn addr=%h wdata=%h rsp_valid=%b rdata=%h err=%b timeout=%b latency=%0d",
               bus_if.sys_addr_o, bus_if.sys_wdata_o, bus_if.rsp_valid_o,
               bus_if.rsp_rdata_o, bus_if.rsp_err_o, bus_if.rsp_timeout_o, lat);
   endtask

   task automatic test_reset();
      tick(); tick();
      n_checks++; if (bus_if.cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready got %b exp 1", bus_if.cmd_ready_o); end
      n_checks++; if (bus_if.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", bus_if.busy_o); end
      n_checks++; if (bus_if.rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b exp 0", bus_if.rsp_valid_o); end
      n_checks++; if ({bus_if.sys_wen_o, bus_if.sys_ren_o} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes got %b exp 00", {bus_if.sys_wen_o, bus_if.sys_ren_o}); end
      n_checks++; if (bus_if.sys_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_sys_addr got %h exp 0", bus_if.sys_addr_o); end
      n_checks++; if ({bus_if.rsp_rdata_o, bus_if.rsp_err_o, bus_if.rsp_timeout_o} !== 34'h0) begin n_fail++; $display("FAIL reset_rsp_fields got %h exp 0", {bus_if.rsp_rdata_o, bus_if.rsp_err_o, bus_if.rsp_timeout_o}); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_write();
      int lat, w0, r0;
      slave_mode = 2'd0; slave_err = 1'b0; slave_rdata = 32'h5A5A_5A5A;
      bus_if.rsp_ready_i = 1'b0;
      w0 = wen_cnt; r0 = ren_cnt;
      issue(1'b1, 32'h04, 32'h5, 4'hF);
      n_checks++; if (bus_if.sys_wen_o !== 1'b1) begin n_fail++; $display("FAIL wr_strobe got %b exp 1", bus_if.sys_wen_o); end
      n_checks++; if (bus_if.sys_addr_o !== 32'h04) begin n_fail++; $display("FAIL wr_addr got %h exp 00000004", bus_if.sys_addr_o); end
      n_checks++; if (bus_if.sys_wdata_o !== 32'h5) begin n_fail++; $display("FAIL wr_wdata got %h exp 00000005", bus_if.sys_wdata_o); end
      n_checks++; if (bus_if.sys_sel_o !== 4'hF) begin n_fail++; $display("FAIL wr_sel got %h exp f", bus_if.sys_sel_o); end
      n_checks++; if ({bus_if.cmd_ready_o, bus_if.busy_o} !== 2'b01) begin n_fail++; $display("FAIL wr_busy got %b exp 01", {bus_if.cmd_ready_o, bus_if.busy_o}); end
      wait_rsp(40, lat);
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL wr_latency got %0d exp 2", lat); end
      n_checks++; if (bus_if.rsp_rdata_o !== 32'h0) begin n_fail++; $display("FAIL wr_rdata got %h exp 0", bus_if.rsp_rdata_o); end
      n_checks++; if ({bus_if.rsp_err_o, bus_if.rsp_timeout_o} !== 2'b00) begin n_fail++; $display("FAIL wr_err got %b exp 00", {bus_if.rsp_err_o, bus_if.rsp_timeout_o}); end
      n_checks++; if ((wen_cnt - w0) !== 1 || (ren_cnt - r0) !== 0) begin n_fail++; $display("FAIL wr_pulses got wen=%0d ren=%0d exp 1/0", wen_cnt - w0, ren_cnt - r0); end
      bus_if.rsp_ready_i = 1'b1;
      tick();
      n_checks++; if ({bus_if.rsp_valid_o, bus_if.cmd_ready_o} !== 2'b01) begin n_fail++; $display("FAIL wr_handshake got %b exp 01", {bus_if.rsp_valid_o, bus_if.cmd_ready_o}); end
      bus_if.rsp_ready_i = 1'b0;
   endtask

   task automatic test_read();
      int lat, w0, r0;
      slave_mode = 2'd0; slave_err = 1'b0; slave_rdata = 32'h0000_00A5;
      w0 = wen_cnt; r0 = ren_cnt;
      issue(1'b0, 32'h00, 32'hCAFE_0000, 4'hF);
      n_checks++; if ({bus_if.sys_ren_o, bus_if.sys_wen_o} !== 2'b10) begin n_fail++; $display("FAIL rd_strobe got %b exp 10", {bus_if.sys_ren_o, bus_if.sys_wen_o}); end
      wait_rsp(40, lat);
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL rd_latency got %0d exp 2", lat); end
      n_checks++; if (bus_if.rsp_rdata_o !== 32'h0000_00A5) begin n_fail++; $display("FAIL rd_rdata got %h exp 000000a5", bus_if.rsp_rdata_o); end
      n_checks++; if ((ren_cnt - r0) !== 1 || (wen_cnt - w0) !== 0) begin n_fail++; $display("FAIL rd_pulses got ren=%0d wen=%0d exp 1/0", ren_cnt - r0, wen_cnt - w0); end
      bus_if.rsp_ready_i = 1'b1;
      tick();
      bus_if.rsp_ready_i = 1'b0;
   endtask

   task automatic test_backpressure();
      int lat, w0, r0, bad;
      slave_mode = 2'd0; slave_err = 1'b0; slave_rdata = 32'h1234_5678;
      issue(1'b0, 32'h10, 32'h0, 4'h3);
      wait_rsp(40, lat);
      // Next command waits on the port while the response is stalled.
      bus_if.cmd_valid_i = 1'b1; bus_if.cmd_we_i = 1'b1;
      bus_if.cmd_addr_i = 32'h20; bus_if.cmd_wdata_i = 32'h0000_BEEF; bus_if.cmd_sel_i = 4'h1;
      w0 = wen_cnt; r0 = ren_cnt; bad = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus_if.rsp_valid_o !== 1'b1 || bus_if.rsp_rdata_o !== 32'h1234_5678 ||
             bus_if.cmd_ready_o !== 1'b0) bad++;
      end
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL bp_hold got %0d bad cycles exp 0", bad); end
      n_checks++; if ((wen_cnt - w0) !== 0 || (ren_cnt - r0) !== 0) begin n_fail++; $display("FAIL bp_no_strobe got wen=%0d ren=%0d exp 0/0", wen_cnt - w0, ren_cnt - r0); end
      bus_if.rsp_ready_i = 1'b1;
      tick();
      n_checks++; if ({bus_if.rsp_valid_o, bus_if.cmd_ready_o, bus_if.sys_wen_o} !== 3'b010) begin n_fail++; $display("FAIL bp_handshake got %b exp 010", {bus_if.rsp_valid_o, bus_if.cmd_ready_o, bus_if.sys_wen_o}); end
      tick();
      bus_if.cmd_valid_i = 1'b0;
      n_checks++; if ({bus_if.sys_wen_o, bus_if.sys_addr_o} !== {1'b1, 32'h20}) begin n_fail++; $display("FAIL bp_next_accept got wen=%b addr=%h exp 1/00000020", bus_if.sys_wen_o, bus_if.sys_addr_o); end
      wait_rsp(40, lat);
      n_checks++; if (lat !== 2 || bus_if.rsp_rdata_o !== 32'h0) begin n_fail++; $display("FAIL bp_second_rsp got lat=%0d rdata=%h exp 2/0", lat, bus_if.rsp_rdata_o); end
      tick();
      bus_if.rsp_ready_i = 1'b0;
   endtask

   task automatic test_slave_err();
      int lat;
      slave_mode = 2'd0; slave_err = 1'b1; slave_rdata = 32'hDEAD_0008;
      issue(1'b0, 32'h08, 32'h0, 4'hF);
      wait_rsp(40, lat);
      n_checks++; if ({bus_if.rsp_err_o, bus_if.rsp_timeout_o} !== 2'b10) begin n_fail++; $display("FAIL err_flags got %b exp 10", {bus_if.rsp_err_o, bus_if.rsp_timeout_o}); end
      n_checks++; if (bus_if.rsp_rdata_o !== 32'hDEAD_0008) begin n_fail++; $display("FAIL err_rdata got %h exp dead0008", bus_if.rsp_rdata_o); end
      bus_if.rsp_ready_i = 1'b1;
      tick();
      bus_if.rsp_ready_i = 1'b0;
      slave_err = 1'b0;
   endtask

   task automatic test_comb_ack();
      int lat;
      slave_mode = 2'd1; slave_rdata = 32'hFFFF_FFFF;
      issue(1'b0, 32'hFFFF_0000, 32'h0, 4'hF);
      wait_rsp(40, lat);
      n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL comb_latency got %0d exp 1", lat); end
      n_checks++; if ({bus_if.rsp_rdata_o, bus_if.rsp_err_o} !== {32'hFFFF_FFFF, 1'b0}) begin n_fail++; $display("FAIL comb_unmapped got rdata=%h err=%b exp ffffffff/0", bus_if.rsp_rdata_o, bus_if.rsp_err_o); end
      bus_if.rsp_ready_i = 1'b1;
      tick();
      bus_if.rsp_ready_i = 1'b0;
      // Acks while idle must never produce a response.
      slave_mode = 2'd2; man_ack = 1'b1;
      tick(); tick(); tick();
      man_ack = 1'b0;
      n_checks++; if ({bus_if.rsp_valid_o, bus_if.busy_o} !== 2'b00) begin n_fail++; $display("FAIL idle_ack got %b exp 00", {bus_if.rsp_valid_o, bus_if.busy_o}); end
   endtask

`ifdef SYS_BUS_MASTER_TIMEOUT_EN
   task automatic test_timeout();
      int lat;
      slave_mode = 2'd2; man_ack = 1'b0; slave_rdata = 32'h0000_0077; slave_err = 1'b0;
      issue(1'b0, 32'h30, 32'h0, 4'hF);
      wait_rsp(60, lat);
      n_checks++; if (lat !== int'(TC)) begin n_fail++; $display("FAIL to_latency got %0d exp %0d", lat, TC); end
      n_checks++; if ({bus_if.rsp_rdata_o, bus_if.rsp_err_o, bus_if.rsp_timeout_o} !== {32'hFFFF_FFFF, 2'b11}) begin n_fail++; $display("FAIL to_fields got rdata=%h err=%b to=%b exp ffffffff/1/1", bus_if.rsp_rdata_o, bus_if.rsp_err_o, bus_if.rsp_timeout_o); end
      bus_if.rsp_ready_i = 1'b1;
      tick();
      bus_if.rsp_ready_i = 1'b0;
      // Ack lands in the same WAIT cycle the timeout would fire.
      issue(1'b0, 32'h34, 32'h0, 4'hF);
      for (int i = 1; i < int'(TC); i++) tick();
      n_checks++; if (bus_if.rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL to_early got %b exp 0", bus_if.rsp_valid_o); end
      man_ack = 1'b1;
      tick();
      man_ack = 1'b0;
      n_checks++; if ({bus_if.rsp_valid_o, bus_if.rsp_timeout_o, bus_if.rsp_err_o} !== 3'b100) begin n_fail++; $display("FAIL to_ack_wins got %b exp 100", {bus_if.rsp_valid_o, bus_if.rsp_timeout_o, bus_if.rsp_err_o}); end
      n_checks++; if (bus_if.rsp_rdata_o !== 32'h0000_0077) begin n_fail++; $display("FAIL to_ack_rdata got %h exp 00000077", bus_if.rsp_rdata_o); end
      bus_if.rsp_ready_i = 1'b1;
      tick();
      bus_if.rsp_ready_i = 1'b0;
   endtask
`else
   task automatic test_no_timeout();
      int bad;
      slave_mode = 2'd2; man_ack = 1'b0; slave_rdata = 32'h0000_0077; slave_err = 1'b0;
      issue(1'b0, 32'h30, 32'h0, 4'hF);
      bad = 0;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (bus_if.rsp_valid_o !== 1'b0 || bus_if.busy_o !== 1'b1 || bus_if.rsp_timeout_o !== 1'b0) bad++;
      end
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL nto_wait got %0d bad cycles exp 0", bad); end
      man_ack = 1'b1;
      tick();
      man_ack = 1'b0;
      n_checks++; if ({bus_if.rsp_valid_o, bus_if.rsp_timeout_o, bus_if.rsp_rdata_o} !== {2'b10, 32'h0000_0077}) begin n_fail++; $display("FAIL nto_late_ack got valid=%b to=%b rdata=%h exp 1/0/00000077", bus_if.rsp_valid_o, bus_if.rsp_timeout_o, bus_if.rsp_rdata_o); end
      bus_if.rsp_ready_i = 1'b1;
      tick();
      bus_if.rsp_ready_i = 1'b0;
   endtask
`endif

   task automatic test_reset_mid();
      slave_mode = 2'd2; man_ack = 1'b0;
      issue(1'b1, 32'h40, 32'h0000_1111, 4'hC);
      tick();
      #2 rst = 1'b1;
      #1;
      n_checks++; if ({bus_if.cmd_ready_o, bus_if.busy_o, bus_if.sys_wen_o, bus_if.rsp_valid_o} !== 4'b1000) begin n_fail++; $display("FAIL rstmid_ctrl got %b exp 1000", {bus_if.cmd_ready_o, bus_if.busy_o, bus_if.sys_wen_o, bus_if.rsp_valid_o}); end
      n_checks++; if ({bus_if.sys_addr_o, bus_if.sys_wdata_o, bus_if.sys_sel_o, bus_if.rsp_rdata_o} !== 100'h0) begin n_fail++; $display("FAIL rstmid_data got addr=%h wdata=%h sel=%h rdata=%h exp 0", bus_if.sys_addr_o, bus_if.sys_wdata_o, bus_if.sys_sel_o, bus_if.rsp_rdata_o); end
      @(posedge clk); #1;
      rst = 1'b0;
      tick();
      man_ack = 1'b1;
      tick();
      man_ack = 1'b0;
      tick();
      n_checks++; if ({bus_if.rsp_valid_o, bus_if.cmd_ready_o, bus_if.busy_o} !== 3'b010) begin n_fail++; $display("FAIL rstmid_late_ack got %b exp 010", {bus_if.rsp_valid_o, bus_if.cmd_ready_o, bus_if.busy_o}); end
   endtask

   initial begin
      bus_if.cmd_valid_i = 1'b0;
      bus_if.cmd_we_i    = 1'b0;
      bus_if.cmd_addr_i  = 32'h0;
      bus_if.cmd_wdata_i = 32'h0;
      bus_if.cmd_sel_i   = 4'h0;
      bus_if.rsp_ready_i = 1'b0;
      test_reset();
      test_write();
      test_read();
      test_backpressure();
      test_slave_err();
      test_comb_ack();
`ifdef SYS_BUS_MASTER_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired before end of test");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sys_bus_master.md
# sys_bus_master

System-bus initiator. It accepts single read/write commands on a local valid/ready port and drives the PS-side system bus (`sys_addr`, `sys_wdata`, `sys_sel`, `sys_wen`, `sys_ren`). It then waits for `sys_ack`, returns read data and error status on a response port, and optionally aborts hung transfers with a timeout. It sits between PL-side sequencers and the register/FIFO slaves on the system bus, so PL logic can program slave registers without PS involvement.

## Interface
- `TIMEOUT_CYC`, default 255: maximum cycles spent in WAIT before abort. Range 2..65535; used only when timeout is compiled in.
- `sys_clk_i` in 1: single clock, shared with the bus slaves.
- `sys_rst_i` in 1: reset, asynchronous, active-high.
- `cmd_valid_i` in 1: command present.
- `cmd_ready_o` out 1: block can accept a command; high only in IDLE.
- `cmd_we_i` in 1: 1 = write, 0 = read.
- `cmd_addr_i` in 32: bus address.
- `cmd_wdata_i` in 32: write data.
- `cmd_sel_i` in 4: byte selects.
- `rsp_valid_o` out 1: response present.
- `rsp_ready_i` in 1: response consumed.
- `rsp_rdata_o` out 32: read data; 0 for writes.
- `rsp_err_o` out 1: slave error or timeout.
- `rsp_timeout_o` out 1: transfer aborted by timeout.
- `busy_o` out 1: state is not IDLE.
- `sys_addr_o` out 32, `sys_wdata_o` out 32, `sys_sel_o` out 4: bus request fields, all registered.
- `sys_wen_o` out 1, `sys_ren_o` out 1: single-cycle request strobes, registered.
- `sys_rdata_i` in 32, `sys_err_i` in 1, `sys_ack_i` in 1: slave reply.

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state is IDLE.
- Reset values:
  - All `sys_*_o` and `rsp_*_o` outputs: 0.
  - `cmd_ready_o`: 1.
  - `busy_o`: 0.
  - Timeout counter: 0.
- IDLE, when `cmd_valid_i & cmd_ready_o`:
  - Latch addr, wdata, sel and we into the `sys_*_o` registers.
  - Raise `sys_wen_o` (we=1) or `sys_ren_o` (we=0) for exactly one cycle.
  - Clear the timeout counter; go to WAIT.
- WAIT: `sys_addr_o`, `sys_wdata_o` and `sys_sel_o` stay stable until leaving RESP.
  - `sys_ack_i` is sampled on every WAIT cycle, including the strobe cycle, so zero-latency slaves are supported.
- WAIT, when `sys_ack_i` is sampled high:
  - `rsp_rdata_o` <= `sys_rdata_i` for reads, 0 for writes.
  - `rsp_err_o` <= `sys_err_i`; `rsp_timeout_o` <= 0.
  - Go to RESP.
- Ack while in IDLE or RESP: ignored. It never produces a response.
- RESP: `rsp_valid_o` = 1 and all `rsp_*` outputs are held. On `rsp_valid_o & rsp_ready_i`: drop `rsp_valid_o`, go to IDLE.
- Unmapped slave addresses ack with 0xFFFFFFFF. That value is passed through with no special handling.
- Counter width is `$clog2(TIMEOUT_CYC+1)`. It increments once per WAIT cycle and saturates; it does not wrap.

## Timing
- Registered slave (ack one cycle after strobe):
  - Command accepted at edge 0.
  - Strobe high during cycle 0→1.
  - Ack sampled at edge 2.
  - `rsp_valid_o` high from edge 2.
- Command to response latency is 2 cycles with a registered slave, 1 cycle with a combinational-ack slave.
- With `rsp_ready_i` held high, `cmd_ready_o` returns 1 cycle after the response handshake. Minimum spacing is 4 cycles per transfer.
- `cmd_ready_o` is combinational from state only. It never depends on `cmd_valid_i`.
- Ack and timeout expiry in the same cycle: ack wins, so `rsp_timeout_o` = 0.
- Reset asserted mid-transfer (any state):
  - All outputs go to reset values immediately, with no glitch-free guarantee on strobes.
  - The pending response is discarded.
  - Any later slave ack is ignored.

## Configuration
- `SYS_BUS_MASTER_TIMEOUT_EN` defined:
  - When the counter reaches `TIMEOUT_CYC` in WAIT, go to RESP.
  - `rsp_rdata_o` = 0xFFFFFFFF, `rsp_err_o` = 1, `rsp_timeout_o` = 1.
- Not defined:
  - No counter is synthesised, and `rsp_timeout_o` is tied to 0.
  - WAIT persists until ack or reset.

## Test plan
- Write addr 0x04, data 0x00000005, sel 0xF; registered slave model.
  - Required: one `sys_wen_o` pulse with `sys_addr_o`=0x04 and `sys_wdata_o`=0x5.
  - Required: `rsp_valid_o` at edge 2 after accept, `rsp_rdata_o`=0, `rsp_err_o`=0.
- Read addr 0x00; slave returns 0x000000A5.
  - Required: one `sys_ren_o` pulse, `rsp_rdata_o`=0x000000A5, latency 2.
  - Required: `sys_wen_o` never asserted.
- Backpressure: `rsp_ready_i` low for 10 cycles while `cmd_valid_i` stays high.
  - Required: response held constant, `cmd_ready_o`=0, no further strobes.
  - Required: next accept 1 cycle after the handshake.
- Slave acks with `sys_err_i`=1 on read addr 0x08.
  - Required: `rsp_err_o`=1, `rsp_timeout_o`=0, `rsp_rdata_o` equals the slave's data.
- `TIMEOUT_CYC`=16, macro defined, slave never acks.
  - Required: response 16 WAIT cycles after accept, with 0xFFFFFFFF, err=1, timeout=1.
  - Repeat with ack on cycle 16 exactly: required timeout=0.
- Reset asserted in WAIT, then slave ack arrives 1 cycle after release.
  - Required: outputs at reset values, `rsp_valid_o` stays 0, `cmd_ready_o`=1.
